// File: rtl/fft2d_sequencer_if.sv
// Control bundle between the 2D FFT sequencer (master) and its environment (slave):
// start/direction/transposer status in, FFT command, row address and transposer controls out.
interface fft2d_sequencer_if #(
  parameter int ROW_AW = 5
);
  logic              start;
  logic              inverse;
  logic              done_transpose;
  logic              exts_busy;
  logic              done;
  logic [5:0]        f_unified_command;
  logic [ROW_AW-1:0] present_ram_row;
  logic              pass_id;
  logic              transposer_reset;
  logic              do_transpose;
  logic              do_bitreversing;
  logic              error;

  modport master (
    input  start, inverse, done_transpose,
    output exts_busy, done, f_unified_command, present_ram_row, pass_id,
           transposer_reset, do_transpose, do_bitreversing, error
  );

  modport slave (
    output start, inverse, done_transpose,
    input  exts_busy, done, f_unified_command, present_ram_row, pass_id,
           transposer_reset, do_transpose, do_bitreversing, error
  );
endinterface

// File: rtl/fft2d_sequencer.sv
// Sequences row FFT pass, transpose, column FFT pass; all outputs registered alongside the state.
// Optional macro FFT2D_SEQ_TIMEOUT_EN adds a transpose watchdog driving the sticky error flag.
module fft2d_sequencer #(
  parameter int NUM_ROWS       = 32,
  parameter int ROW_CYCLES     = 1543,
  parameter int ROW_AW         = 5,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               extc_base_clock,
  input  logic               extc_sync_reset,
  fft2d_sequencer_if.master  bus
);
  typedef enum logic [2:0] {S_IDLE, S_PASS1, S_XPOSE, S_PASS2, S_FINISH} state_t;

  localparam logic [5:0]        CMD_LOAD = 6'b10_0000;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ROW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(ROW_CYCLES - 2);
  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(NUM_ROWS - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ROW_AW-1:0] r_row;
  logic              r_inv;
  logic [5:0]        r_cmd;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_xrst;
  logic              r_xdo;
  logic [5:0]        w_run_cmd;
`ifdef FFT2D_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]  r_tcnt;
  logic              r_err;
`endif

  assign w_run_cmd = {2'b01, 3'b001, r_inv};

  always_ff @(posedge extc_base_clock) begin
    if (extc_sync_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
      r_inv   <= 1'b0;
      r_cmd   <= CMD_LOAD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_xrst  <= 1'b1;
      r_xdo   <= 1'b0;
`ifdef FFT2D_SEQ_TIMEOUT_EN
      r_tcnt  <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_PASS1;
            r_inv   <= bus.inverse;
            r_cmd   <= {2'b01, 3'b001, bus.inverse};
            r_busy  <= 1'b1;
`ifdef FFT2D_SEQ_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
          end
        end
        S_PASS1, S_PASS2: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_row == ROW_LAST) begin
              r_row <= '0;
              r_cmd <= CMD_LOAD;
              if (r_state == S_PASS1) begin
                r_state <= S_XPOSE;
                r_xrst  <= 1'b0;
                r_xdo   <= 1'b1;
`ifdef FFT2D_SEQ_TIMEOUT_EN
                r_tcnt  <= '0;
`endif
              end else begin
                r_state <= S_FINISH;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_row <= r_row + 1'b1;
              r_cmd <= w_run_cmd;
            end
          end else begin
            // Load is presented on the final cycle of each row, so it is staged one count early.
            r_cnt <= r_cnt + 1'b1;
            r_cmd <= (r_cnt == CNT_PRE) ? CMD_LOAD : w_run_cmd;
          end
        end
        S_XPOSE: begin
          if (bus.done_transpose) begin
            r_state <= S_PASS2;
            r_pass  <= 1'b1;
            r_xrst  <= 1'b1;
            r_xdo   <= 1'b0;
            r_cmd   <= w_run_cmd;
          end
`ifdef FFT2D_SEQ_TIMEOUT_EN
          else if (r_tcnt == TMO_LAST) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
            r_xrst  <= 1'b1;
            r_xdo   <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_pass  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.exts_busy         = r_busy;
  assign bus.done              = r_done;
  assign bus.f_unified_command = r_cmd;
  assign bus.present_ram_row   = r_row;
  assign bus.pass_id           = r_pass;
  assign bus.transposer_reset  = r_xrst;
  assign bus.do_transpose      = r_xdo;
  assign bus.do_bitreversing   = 1'b1;
`ifdef FFT2D_SEQ_TIMEOUT_EN
  assign bus.error             = r_err;
`else
  assign bus.error             = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif
endmodule

// File: tb/tb_fft2d_sequencer.sv
// Directed bench for fft2d_sequencer with a small cycle model and a done-latency scoreboard.
module tb_fft2d_sequencer;
  localparam int NR  = 4;
  localparam int RC  = 8;
  localparam int TMO = 16;
  localparam logic [5:0] CMD_LOAD = 6'b10_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   lat_q[$];

  fft2d_sequencer_if #(.ROW_AW(2)) bus ();

  fft2d_sequencer #(
    .NUM_ROWS(NR), .ROW_CYCLES(RC), .ROW_AW(2), .CNT_W(16), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .extc_base_clock(clk),
    .extc_sync_reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] obs_vec();
    return {bus.exts_busy, bus.done, bus.f_unified_command, bus.present_ram_row, bus.pass_id,
            bus.transposer_reset, bus.do_transpose, bus.do_bitreversing, bus.error};
  endfunction

  function automatic logic [14:0] mk(input bit busy, input bit dn, input logic [5:0] cmd,
                                     input logic [1:0] row, input bit pass, input bit xrst,
                                     input bit xdo, input bit err);
    return {busy, dn, cmd, row, pass, xrst, xdo, 1'b1, err};
  endfunction

  function automatic logic [14:0] idle_vec(input bit err);
    return mk(1'b0, 1'b0, CMD_LOAD, 2'd0, 1'b0, 1'b1, 1'b0, err);
  endfunction

  // Expected outputs in cycle k after the accepted-start edge, transpose lasting T cycles.
  function automatic logic [14:0] exp_vec(input int k, input bit inv, input int T);
    int p;
    logic [5:0] run;
    run = {2'b01, 3'b001, inv};
    if (k <= NR*RC) begin
      p = k - 1;
      return mk(1'b1, 1'b0, (p % RC == RC-1) ? CMD_LOAD : run, 2'(p / RC), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    if (k <= NR*RC + T)
      return mk(1'b1, 1'b0, CMD_LOAD, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    if (k <= 2*NR*RC + T) begin
      p = k - 1 - NR*RC - T;
      return mk(1'b1, 1'b0, (p % RC == RC-1) ? CMD_LOAD : run, 2'(p / RC), 1'b1, 1'b1, 1'b0, 1'b0);
    end
    return mk(1'b0, 1'b1, CMD_LOAD, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic run_xform(input bit inv, input int T, input bit hold, input bit poke,
                           input int abort_at);
    bit seen;
    bit aborted;
    int nd;
    int limit;
    seen    = 1'b0;
    aborted = 1'b0;
    limit   = 2*NR*RC + T + 6;
    @(negedge clk);
    bus.start          = 1'b1;
    bus.inverse        = inv;
    bus.done_transpose = hold;
    lat_q.push_back(2*NR*RC + T + 1);
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (abort_at > 0 && k == abort_at + 1) begin
        rst = 1'b0;
        chk("abort_idle", obs_vec(), idle_vec(1'b0));
        lat_q.delete();
        aborted = 1'b1;
        break;
      end
      chk($sformatf("cycle%0d", k), obs_vec(), exp_vec(k, inv, T));
      if (bus.done) begin
        seen = 1'b1;
        if (lat_q.size() == 0) chk("unexpected_done", k, 0);
        else chk("done_latency", k, lat_q.pop_front());
        break;
      end
      if (k == 1) begin
        bus.start   = 1'b0;
        bus.inverse = ~inv;
      end
      if (poke && k == 10) bus.start = 1'b1;
      if (poke && k == 11) bus.start = 1'b0;
      if (!hold && k == 5) bus.done_transpose = 1'b1;
      if (!hold && k == 6) bus.done_transpose = 1'b0;
      if (!hold && k == NR*RC + T) bus.done_transpose = 1'b1;
      if (!hold && k == NR*RC + T + 1) bus.done_transpose = 1'b0;
      if (k == abort_at) rst = 1'b1;
    end
    bus.done_transpose = 1'b0;
    if (aborted) begin
      nd = 0;
      for (int j = 0; j < 80; j++) begin
        @(negedge clk);
        if (bus.done || bus.exts_busy) nd++;
      end
      chk("no_activity_after_abort", nd, 0);
    end else begin
      chk("done_seen", seen, 1);
      if (poke) bus.start = 1'b1;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        bus.start = 1'b0;
        chk("post_idle", obs_vec(), idle_vec(1'b0));
      end
    end
    chk("scoreboard_empty", lat_q.size(), 0);
  endtask

`ifdef FFT2D_SEQ_TIMEOUT_EN
  task automatic run_timeout();
    @(negedge clk);
    bus.start          = 1'b1;
    bus.inverse        = 1'b0;
    bus.done_transpose = 1'b0;
    for (int k = 1; k <= NR*RC + TMO + 1; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k <= NR*RC + TMO) chk($sformatf("tmo_cycle%0d", k), obs_vec(), exp_vec(k, 1'b0, TMO + 100));
      else chk("tmo_idle_error", obs_vec(), idle_vec(1'b1));
    end
  endtask
`endif

  initial begin
    bus.start          = 1'b0;
    bus.inverse        = 1'b0;
    bus.done_transpose = 1'b0;
    rst                = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", obs_vec(), idle_vec(1'b0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold", obs_vec(), idle_vec(1'b0));

    run_xform(1'b0, 5, 1'b0, 1'b0, 0);
    run_xform(1'b1, 5, 1'b0, 1'b0, 0);
    run_xform(1'b0, 1, 1'b1, 1'b0, 0);
    run_xform(1'b1, 5, 1'b0, 1'b0, 2*NR*RC/2 + 1 + 5 + 2*RC + 1);
    run_xform(1'b0, 5, 1'b0, 1'b1, 0);
`ifdef FFT2D_SEQ_TIMEOUT_EN
    run_timeout();
    run_xform(1'b0, 3, 1'b0, 1'b0, 0);
`else
    run_xform(1'b1, 20, 1'b0, 1'b0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft2d_sequencer.md
FFT2D_SEQUENCER -- requirements
Module: fft2d_sequencer

Interface
REQ-001 Parameter NUM_ROWS, default 32, number of RAM rows processed per pass (any value >=2, power of two not required).
REQ-002 Parameter ROW_CYCLES, default 1543, clock cycles per row 1D FFT including the load cycle (>=2).
REQ-003 Parameter ROW_AW, default 5, width of present_ram_row (ROW_AW >= ceil(log2(NUM_ROWS))).
REQ-004 Parameter CNT_W, default 16, width of the internal cycle counter.
REQ-005 Parameter TIMEOUT_CYCLES, default 4096, transpose watchdog limit (used only when the configuration macro is defined).
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 extc_base_clock  in  1  sole clock, all logic on rising edge.
REQ-008 extc_sync_reset  in  1  synchronous active-high reset.
REQ-009 start  in  1  request a full 2D transform; sampled only in IDLE.
REQ-010 inverse  in  1  transform direction, sampled with accepted start (1 = IFFT).
REQ-011 done_transpose  in  1  transposer completion level.
REQ-012 exts_busy  out  1  high from the cycle after accepted start through the last PASS2 cycle.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 f_unified_command  out  6  {load, run, mode[3:0]} to all 1D FFT units.
REQ-015 present_ram_row  out  ROW_AW  row currently addressed.
REQ-016 pass_id  out  1  0 during PASS1, 1 during PASS2 and FINISH.
REQ-017 transposer_reset, do_transpose, do_bitreversing  out  1 each  transposer control.
REQ-018 error  out  1  sticky transpose-timeout flag.

Function
REQ-019 States: IDLE, PASS1, XPOSE, PASS2, FINISH; all outputs are registered and update on the same edge as the state.
REQ-020 IDLE: counter=0, row=0, command={1,0,0000}, transposer_reset=1, do_transpose=0, do_bitreversing=1, exts_busy=0, done=0; start=1 -> PASS1, latch inverse, clear error.
REQ-021 PASS1/PASS2: exts_busy=1; counter increments each cycle; command={0,1,mode} with mode=0010 forward, 0011 inverse.
REQ-022 When counter==ROW_CYCLES-1: counter->0, command={1,0,0000} for that cycle, row increments; if row==NUM_ROWS-1, row wraps to 0 and PASS1->XPOSE or PASS2->FINISH.
REQ-023 XPOSE: exts_busy=1; while done_transpose=0 drive do_transpose=1, transposer_reset=0; on done_transpose=1 drive do_transpose=0, transposer_reset=1, go to PASS2 (also if high on the first XPOSE cycle).
REQ-024 done_transpose is ignored in all states other than XPOSE.
REQ-025 FINISH: done=1, exts_busy=0 for exactly one cycle, then IDLE.
REQ-026 start in any state other than IDLE is ignored; start in FINISH is ignored.
REQ-027 One transform takes 2*NUM_ROWS*ROW_CYCLES + T_xpose + 1 cycles from accepted start to done.

Reset
REQ-028 extc_sync_reset=1 at any edge, including mid-pass or mid-transpose, forces IDLE with REQ-020 output values and error=0; in-progress transform is abandoned, no done pulse.

Configuration
REQ-029 Macro FFT2D_SEQ_TIMEOUT_EN: when defined, a counter runs in XPOSE; reaching TIMEOUT_CYCLES without done_transpose sets error=1, drives transposer_reset=1, do_transpose=0 and returns to IDLE without done.
REQ-030 Without FFT2D_SEQ_TIMEOUT_EN, XPOSE waits indefinitely and error is constant 0.

Verification (NUM_ROWS=4, ROW_CYCLES=8, TIMEOUT_CYCLES=16)
REQ-031 start=1, inverse=0, done_transpose after 5 XPOSE cycles -> 32 PASS1 cycles with load at counter 7, rows 0..3, mode 0010; done pulse at cycle 70 after start.
REQ-032 Same with inverse=1 -> run command {0,1,0011} in both passes, pass_id toggles 0->1 after XPOSE.
REQ-033 done_transpose held high throughout -> XPOSE lasts one cycle, done at cycle 66.
REQ-034 Reset asserted at PASS2 row 2 -> next cycle IDLE outputs, row=0, no done; new start runs normally.
REQ-035 With FFT2D_SEQ_TIMEOUT_EN, done_transpose never rises -> error=1 after 16 XPOSE cycles, IDLE, no done; next start clears error.
REQ-036 start pulses during PASS1 and FINISH -> ignored, single done per accepted start.
